// File: rtl/block_acc_sequencer.sv
// rtl/block_acc_sequencer.sv - drives one 2x2 block accumulator through a block-matrix product
// Optional watchdog on the accumulator add: define BLOCK_ACC_SEQ_TIMEOUT_EN.
module block_acc_sequencer #(
   parameter int K_W         = 8,
   parameter int BLK_W       = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [K_W-1:0]   cfg_k,
   input  logic [BLK_W-1:0] cfg_blocks,
   output logic             busy,
   output logic             run_done,
   input  logic             pp_valid,
   output logic             pp_ready,
   input  logic [31:0]      pp_a11,
   input  logic [31:0]      pp_a12,
   input  logic [31:0]      pp_a21,
   input  logic [31:0]      pp_a22,
   output logic             acc_start,
   output logic             acc_reset,
   output logic [31:0]      acc_in_a11,
   output logic [31:0]      acc_in_a12,
   output logic [31:0]      acc_in_a21,
   output logic [31:0]      acc_in_a22,
   input  logic             acc_done,
   input  logic [31:0]      acc_a11,
   input  logic [31:0]      acc_a12,
   input  logic [31:0]      acc_a21,
   input  logic [31:0]      acc_a22,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_a11,
   output logic [31:0]      out_a12,
   output logic [31:0]      out_a21,
   output logic [31:0]      out_a22,
   output logic             err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_CLEAR_WAIT, S_FETCH, S_ISSUE, S_WAIT_DONE, S_GAP, S_OUTPUT
   } state_t;

   state_t           state;
   logic [K_W-1:0]   k_cnt;
   logic [K_W-1:0]   k_cfg;
   logic [BLK_W-1:0] blk_cnt;
   logic [BLK_W-1:0] blk_cfg;
   logic [BLK_W:0]   blk_next;

   // One extra bit so cfg_blocks at its maximum still compares without wrap.
   assign blk_next = {1'b0, blk_cnt} + 1'b1;

`ifdef BLOCK_ACC_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0] wd_cnt;
`else
   // No watchdog: the flag is constant low (the comparison is always false).
   assign err_timeout = (TIMEOUT_CYC < 0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         k_cnt      <= '0;
         k_cfg      <= '0;
         blk_cnt    <= '0;
         blk_cfg    <= '0;
         busy       <= 1'b0;
         run_done   <= 1'b0;
         pp_ready   <= 1'b0;
         acc_start  <= 1'b0;
         acc_reset  <= 1'b1;
         acc_in_a11 <= '0;
         acc_in_a12 <= '0;
         acc_in_a21 <= '0;
         acc_in_a22 <= '0;
         out_valid  <= 1'b0;
         out_a11    <= '0;
         out_a12    <= '0;
         out_a21    <= '0;
         out_a22    <= '0;
`ifdef BLOCK_ACC_SEQ_TIMEOUT_EN
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
         run_done  <= 1'b0;
         acc_start <= 1'b0;
         acc_reset <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  k_cfg   <= cfg_k;
                  blk_cfg <= cfg_blocks;
                  blk_cnt <= '0;
                  if (cfg_blocks == '0) begin
                     run_done <= 1'b1;
                  end else begin
                     busy      <= 1'b1;
                     acc_reset <= 1'b1;
                     state     <= S_CLEAR;
                  end
               end
            end
            S_CLEAR: begin
               k_cnt <= '0;
               state <= S_CLEAR_WAIT;
            end
            S_CLEAR_WAIT: begin
               if (k_cfg == '0) begin
                  out_a11   <= acc_a11;
                  out_a12   <= acc_a12;
                  out_a21   <= acc_a21;
                  out_a22   <= acc_a22;
                  out_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else begin
                  pp_ready <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (pp_valid && pp_ready) begin
                  acc_in_a11 <= pp_a11;
                  acc_in_a12 <= pp_a12;
                  acc_in_a21 <= pp_a21;
                  acc_in_a22 <= pp_a22;
                  pp_ready   <= 1'b0;
                  acc_start  <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
`ifdef BLOCK_ACC_SEQ_TIMEOUT_EN
               wd_cnt <= '0;
`endif
               state <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (acc_done) begin
                  k_cnt <= k_cnt + 1'b1;
                  state <= S_GAP;
               end
`ifdef BLOCK_ACC_SEQ_TIMEOUT_EN
               else if (wd_cnt == WD_LAST) begin
                  err_timeout <= 1'b1;
                  acc_reset   <= 1'b1;
                  run_done    <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            S_GAP: begin
               if (k_cnt == k_cfg) begin
                  out_a11   <= acc_a11;
                  out_a12   <= acc_a12;
                  out_a21   <= acc_a21;
                  out_a22   <= acc_a22;
                  out_valid <= 1'b1;
                  state     <= S_OUTPUT;
               end else begin
                  pp_ready <= 1'b1;
                  state    <= S_FETCH;
               end
            end
            S_OUTPUT: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  blk_cnt   <= blk_next[BLK_W-1:0];
                  if (blk_next == {1'b0, blk_cfg}) begin
                     run_done <= 1'b1;
                     busy     <= 1'b0;
                     state    <= S_IDLE;
                  end else begin
                     acc_reset <= 1'b1;
                     state     <= S_CLEAR;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_acc_sequencer.sv
// tb/tb_block_acc_sequencer.sv - scoreboard bench for block_acc_sequencer with an accumulator model
module tb_block_acc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        go = 1'b0;
   logic [7:0]  cfg_k = '0;
   logic [7:0]  cfg_blocks = '0;
   logic        busy, run_done;
   logic        pp_valid = 1'b0;
   logic        pp_ready;
   logic [31:0] pp_a11 = '0, pp_a12 = '0, pp_a21 = '0, pp_a22 = '0;
   logic        acc_start, acc_reset;
   logic [31:0] acc_in_a11, acc_in_a12, acc_in_a21, acc_in_a22;
   logic        acc_done = 1'b0;
   logic [31:0] acc_a11 = '0, acc_a12 = '0, acc_a21 = '0, acc_a22 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_a11, out_a12, out_a21, out_a22;
   logic        err_timeout;

   block_acc_sequencer #(.K_W(8), .BLK_W(8), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .reset(reset), .go(go), .cfg_k(cfg_k), .cfg_blocks(cfg_blocks),
      .busy(busy), .run_done(run_done),
      .pp_valid(pp_valid), .pp_ready(pp_ready),
      .pp_a11(pp_a11), .pp_a12(pp_a12), .pp_a21(pp_a21), .pp_a22(pp_a22),
      .acc_start(acc_start), .acc_reset(acc_reset),
      .acc_in_a11(acc_in_a11), .acc_in_a12(acc_in_a12), .acc_in_a21(acc_in_a21), .acc_in_a22(acc_in_a22),
      .acc_done(acc_done),
      .acc_a11(acc_a11), .acc_a12(acc_a12), .acc_a21(acc_a21), .acc_a22(acc_a22),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a11(out_a11), .out_a12(out_a12), .out_a21(out_a21), .out_a22(out_a22),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_start = 0, n_reset = 0, n_done = 0;
   logic [127:0] pp_q[$];
   logic [127:0] exp_q[$];
   logic         hang = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] blk(input int a, input int b, input int c, input int d);
      return {a[31:0], b[31:0], c[31:0], d[31:0]};
   endfunction

   // Accumulator model: latches inputs on start, adds and pulses done two cycles later.
   logic [1:0]   lat = '0;
   logic [127:0] lat_in = '0;
   always @(posedge clk) begin
      acc_done <= 1'b0;
      if (acc_reset) begin
         {acc_a11, acc_a12, acc_a21, acc_a22} <= '0;
         lat <= '0;
      end else if (acc_start) begin
         lat_in <= {acc_in_a11, acc_in_a12, acc_in_a21, acc_in_a22};
         lat    <= 2'd2;
      end else if (lat != 0) begin
         lat <= lat - 1'b1;
         if (lat == 2'd1 && !hang) begin
            acc_a11  <= acc_a11 + lat_in[127:96];
            acc_a12  <= acc_a12 + lat_in[95:64];
            acc_a21  <= acc_a21 + lat_in[63:32];
            acc_a22  <= acc_a22 + lat_in[31:0];
            acc_done <= 1'b1;
         end
      end
   end

   // Partial-product source: presents the head of pp_q, pops on handshake.
   always @(posedge clk) begin
      if (pp_valid && pp_ready) void'(pp_q.pop_front());
      #1;
      pp_valid = (pp_q.size() != 0);
      if (pp_q.size() != 0) {pp_a11, pp_a12, pp_a21, pp_a22} = pp_q[0];
   end

   // Monitor: counts pulses and scores every result handshake.
   always @(negedge clk) begin
      if (acc_start) n_start++;
      if (acc_reset) n_reset++;
      if (run_done)  n_done++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected_out", 1, 0);
         else check("out_block", {out_a11, out_a12, out_a21, out_a22}, exp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_go(input int k, input int b);
      cfg_k = k[7:0];
      cfg_blocks = b[7:0];
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic clear_counts();
      n_start = 0;
      n_reset = 0;
      n_done = 0;
   endtask

   task automatic wait_run_done(input int budget);
      int n = 0;
      while (!run_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("run_done_seen", run_done, 1);
      check("scoreboard_drained", exp_q.size(), 0);
      repeat (2) tick();
   endtask

   task automatic wait_start(input int budget);
      int n = 0;
      @(negedge clk);
      while (!acc_start && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("acc_start_seen", acc_start, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [127:0] held;
      int n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", {acc_reset, busy, run_done, pp_ready, acc_start, out_valid, err_timeout}, 7'b1000000);
      check("reset_out", {out_a11, out_a12, out_a21, out_a22}, 0);
      check("reset_acc_in", {acc_in_a11, acc_in_a12, acc_in_a21, acc_in_a22}, 0);
      tick();
      reset = 1'b0;
      repeat (2) tick();

      // Single block, k=3
      clear_counts();
      pp_q.push_back(blk(1, 2, 3, 4));
      pp_q.push_back(blk(10, 20, 30, 40));
      pp_q.push_back(blk(100, 200, 300, 400));
      exp_q.push_back(blk(111, 222, 333, 444));
      pulse_go(3, 1);
      check("busy_after_go", busy, 1);
      wait_run_done(200);
      check("single_starts", n_start, 3);
      check("single_resets", n_reset, 1);
      check("single_done", n_done, 1);

      // Two blocks, accumulator cleared between them
      clear_counts();
      pp_q.push_back(blk(1, 1, 1, 1));
      pp_q.push_back(blk(1, 1, 1, 1));
      pp_q.push_back(blk(5, 5, 5, 5));
      pp_q.push_back(blk(5, 5, 5, 5));
      exp_q.push_back(blk(2, 2, 2, 2));
      exp_q.push_back(blk(10, 10, 10, 10));
      pulse_go(2, 2);
      wait_run_done(300);
      check("multi_starts", n_start, 4);
      check("multi_resets", n_reset, 2);
      check("multi_done", n_done, 1);

      // Backpressure on the result
      out_ready = 1'b0;
      pp_q.push_back(blk(7, 8, 9, 10));
      exp_q.push_back(blk(7, 8, 9, 10));
      pulse_go(1, 1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", out_valid, 1);
      held = {out_a11, out_a12, out_a21, out_a22};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", {out_valid, pp_ready, out_a11, out_a12, out_a21, out_a22}, {1'b1, 1'b0, held});
      end
      tick();
      out_ready = 1'b1;
      tick();
      check("bp_accept", out_valid, 0);
      wait_run_done(20);

      // k=0 emits the cleared block
      clear_counts();
      exp_q.push_back(blk(0, 0, 0, 0));
      pulse_go(0, 1);
      wait_run_done(50);
      check("k0_starts", n_start, 0);

      // blocks=0 finishes immediately
      pulse_go(3, 0);
      check("b0_done_busy", {run_done, busy}, 2'b10);
      tick();
      check("b0_done_once", {run_done, busy}, 2'b00);

      // go while busy is ignored
      clear_counts();
      exp_q.push_back(blk(2, 4, 6, 8));
      pulse_go(1, 1);
      repeat (3) tick();
      pulse_go(5, 3);
      pp_q.push_back(blk(2, 4, 6, 8));
      wait_run_done(100);
      check("gobusy_starts", n_start, 1);
      check("gobusy_done", n_done, 1);
      check("gobusy_idle", busy, 0);

      // Reset in WAIT_DONE, then a clean run
      pp_q.push_back(blk(9, 9, 9, 9));
      pulse_go(2, 1);
      wait_start(50);
      tick();
      reset = 1'b1;
      tick();
      check("midrst_state", {busy, acc_reset, out_valid}, 3'b010);
      reset = 1'b0;
      pp_q.delete();
      tick();
      exp_q.push_back(blk(3, 4, 5, 6));
      pp_q.push_back(blk(3, 4, 5, 6));
      pulse_go(1, 1);
      wait_run_done(100);

`ifdef BLOCK_ACC_SEQ_TIMEOUT_EN
      hang = 1'b1;
      pp_q.push_back(blk(1, 1, 1, 1));
      pulse_go(1, 1);
      wait_start(50);
      n = 0;
      while (!run_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("to_latency", n, 9);
      check("to_flag", {err_timeout, out_valid}, 2'b10);
      hang = 1'b0;
      repeat (3) tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/block_acc_sequencer.md
Name: block_acc_sequencer

Overview:
- Sequences one 2x2 block accumulator (start/reset/done, 4x32-bit in/out) through a full block-matrix product.
- Per output block: clears the accumulator, feeds cfg_k partial-product blocks from the multiplier stream one at a time, then emits the accumulated 2x2 result downstream.
- Repeats for cfg_blocks output blocks.
- Sits between the block multiplier output stream and the result writer.

Parameters:
- K_W, 8, width of cfg_k and the partial-product counter.
- BLK_W, 8, width of cfg_blocks and the block counter.
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- go  in  1  single-cycle pulse; starts a run; ignored while busy
- cfg_k  in  K_W  partial products per output block; sampled on go
- cfg_blocks  in  BLK_W  output blocks per run; sampled on go
- busy  out  1  high from the cycle after an accepted go until run_done
- run_done  out  1  single-cycle pulse when the last block has been handed off
- pp_valid  in  1  partial-product block valid
- pp_ready  out  1  sequencer accepts a partial product
- pp_a11, pp_a12, pp_a21, pp_a22  in  32 each  partial-product elements
- acc_start  out  1  single-cycle start pulse to the accumulator
- acc_reset  out  1  single-cycle clear pulse to the accumulator
- acc_in_a11, acc_in_a12, acc_in_a21, acc_in_a22  out  32 each  registered partial product presented to the accumulator
- acc_done  in  1  accumulator add-complete pulse
- acc_a11, acc_a12, acc_a21, acc_a22  in  32 each  accumulator contents
- out_valid  out  1  result block valid
- out_ready  in  1  downstream accepts the result
- out_a11, out_a12, out_a21, out_a22  out  32 each  registered result block
- err_timeout  out  1  sticky watchdog flag; optional feature only, otherwise tied to 0

Behaviour:
- All outputs are registered.
- Reset values: every output is 0 except acc_reset, which is 1. The accumulator therefore clears on the first cycle after reset.
- Reset mid-run aborts everything:
  - counters are zeroed and the state returns to IDLE;
  - any in-flight accumulator add is discarded, because acc_reset=1 forces the accumulator's own clear path.

State machine:
- IDLE: pp_ready=0. On go, latch cfg_k and cfg_blocks, set blk_cnt=0, go to CLEAR.
  - If cfg_blocks==0: pulse run_done next cycle and stay in IDLE; busy never rises.
- CLEAR: acc_reset=1 for exactly 1 cycle, k_cnt=0, go to CLEAR_WAIT. The accumulator needs 2 cycles to return to idle.
- CLEAR_WAIT: 1 cycle, then go to FETCH. If cfg_k==0, go to OUTPUT instead, which emits the cleared block (all zeros).
- FETCH: pp_ready=1. On pp_valid&&pp_ready, register pp_a* into acc_in_a* and go to ISSUE. At most one transfer per visit.
- ISSUE: acc_start=1 for 1 cycle, then go to WAIT_DONE.
  - acc_in_a* must stay stable from the ISSUE cycle through the following cycle, because the accumulator latches them on the cycle it sees start.
- WAIT_DONE: wait for acc_done, then k_cnt++ and go to GAP.
- GAP: 1 cycle, covering the accumulator's post-done wait state.
  - If k_cnt==cfg_k, go to OUTPUT; otherwise go to FETCH.
  - k_cnt is compared at full K_W width, with no wrap (cfg_k max 2^K_W-1).
- OUTPUT: capture acc_a* into out_a* and set out_valid=1. out_a* and out_valid hold until out_ready.
  - On out_valid&&out_ready: out_valid=0 and blk_cnt++.
  - If blk_cnt+1==cfg_blocks: run_done=1 for 1 cycle and go to IDLE. Otherwise go to CLEAR.
- acc_done is ignored outside WAIT_DONE.
- pp_ready is 0 in every state except FETCH.
- go during busy has no effect.

Latency:
- Minimum per partial product (pp_valid held high): 1 (FETCH) + 1 (ISSUE) + accumulator latency + 1 (GAP).
- Per block overhead: 2 cycles of clear, plus the out handshake.

Optional Feature:
- Macro: BLOCK_ACC_SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in WAIT_DONE.
  - If acc_done has not arrived within TIMEOUT_CYC cycles: set err_timeout (sticky until reset), assert acc_reset for 1 cycle, pulse run_done, return to IDLE. No out_valid is produced for the aborted block.
- Undefined: no counter is built, err_timeout is constant 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Single block: go with cfg_k=3, cfg_blocks=1; pp blocks {1,2,3,4}, {10,20,30,40}, {100,200,300,400} with accumulator model → out_a* = {111,222,333,444}; exactly 3 acc_start pulses, 1 acc_reset pulse after reset plus 1 after go; run_done once, after the out handshake.
- Multi-block clear: cfg_k=2, cfg_blocks=2; block0 pps {1,1,1,1}×2, block1 {5,5,5,5}×2 → out0={2,2,2,2}, out1={10,10,10,10}; acc_reset pulses between the blocks, so there is no carry-over.
- Backpressure: hold out_ready=0 for 10 cycles during OUTPUT → out_valid and out_a* stable and pp_ready=0 throughout; accepted on the first cycle out_ready=1.
- Edge configs:
  - cfg_k=0, cfg_blocks=1 → out_a*=0 with no acc_start.
  - cfg_blocks=0 → run_done the cycle after go, busy stays 0.
  - go while busy → ignored.
- Reset mid-run: assert reset in WAIT_DONE of block 0 → next cycle busy=0, acc_reset=1, out_valid=0. A fresh go then completes a cfg_k=1 run with the correct value.
- Timeout (macro defined, TIMEOUT_CYC=8): accumulator model never returns acc_done → err_timeout=1 and run_done pulse 8 cycles into WAIT_DONE; no out_valid.
